// File: rtl/fakeram_init_pkg.sv
// Shared widths and the response entry layout for the fakeram 256x64 initiator.
// The entry pairs the RAM word with a flag recording whether the access was a write.
package fakeram_init_pkg;

    localparam int FAKERAM_BITS       = 64;
    localparam int FAKERAM_WORD_DEPTH = 256;
    localparam int FAKERAM_ADDR_WIDTH = 8;
    localparam int FAKERAM_RSP_DEPTH  = 4;

    typedef struct packed {
        logic [FAKERAM_BITS-1:0] rdata;
        logic                    was_write;
    } rsp_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fakeram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; pointers wrap modulo DEPTH.
// The head is registered storage only, so a push becomes visible one cycle later.
module fakeram_rsp_fifo
    import fakeram_init_pkg::*;
#(
    parameter  int WIDTH = $bits(rsp_entry_t),
    parameter  int DEPTH = FAKERAM_RSP_DEPTH,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fakeram_256x64_initiator.sv
// Request-side controller for the 256x64 fakeram: accept -> issue -> capture -> response FIFO.
// Credits cover the FIFO plus both pipeline stages, so a capture push can never overflow.
module fakeram_256x64_initiator
    import fakeram_init_pkg::*;
#(
    parameter int BITS       = FAKERAM_BITS,
    parameter int WORD_DEPTH = FAKERAM_WORD_DEPTH,
    parameter int ADDR_WIDTH = $clog2(WORD_DEPTH),
    parameter int RSP_DEPTH  = FAKERAM_RSP_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [BITS-1:0]       i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [BITS-1:0]       o_rsp_rdata,
    output logic                  o_rsp_was_write,
    output logic                  o_ram_ce,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [BITS-1:0]       o_ram_wd,
    input  logic [BITS-1:0]       i_ram_rd,
    output logic                  o_busy
);

    localparam int CW = count_width(RSP_DEPTH);

    logic                  r_i_valid;
    logic                  r_i_we;
    logic [ADDR_WIDTH-1:0] r_i_addr;
    logic [BITS-1:0]       r_i_wd;
    logic                  r_c_valid;
    logic                  r_c_we;

    logic                  w_accept;
    logic [CW:0]           w_used;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_valid;
    logic                  w_pop;
    rsp_entry_t            w_push_entry;
    rsp_entry_t            w_head;

    // Credit check uses registered state only; reset gating keeps ready low in the reset cycle.
    assign w_used      = (CW+1)'(w_fifo_count) + (CW+1)'(r_i_valid) + (CW+1)'(r_c_valid);
    assign o_req_ready = ~i_reset & (w_used < (CW+1)'(RSP_DEPTH));
    assign w_accept    = i_req_valid & o_req_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_i_valid <= 1'b0;
            r_i_we    <= 1'b0;
            r_i_addr  <= '0;
            r_i_wd    <= '0;
            r_c_valid <= 1'b0;
            r_c_we    <= 1'b0;
        end else begin
            r_i_valid <= w_accept;
            r_i_we    <= w_accept & i_req_we;
            r_i_addr  <= w_accept ? i_req_addr : '0;
            r_i_wd    <= (w_accept && i_req_we) ? i_req_wdata : '0;
            r_c_valid <= r_i_valid;
            r_c_we    <= r_i_we;
        end
    end

    // Idle issue registers are cleared, so the RAM pins sit at known zeros.
    assign o_ram_ce   = r_i_valid;
    assign o_ram_we   = r_i_we;
    assign o_ram_addr = r_i_addr;
    assign o_ram_wd   = r_i_wd;

    assign w_push_entry.rdata     = i_ram_rd;
    assign w_push_entry.was_write = r_c_we;
    assign w_pop                  = w_fifo_valid & i_rsp_ready;

    fakeram_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (r_c_valid),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign o_rsp_valid     = w_fifo_valid;
    assign o_rsp_rdata     = w_head.rdata;
    assign o_rsp_was_write = w_head.was_write;
    assign o_busy          = r_i_valid | r_c_valid | (w_fifo_count != '0);

endmodule

// File: tb/tb_fakeram_256x64_initiator.sv
// Directed bench for the fakeram initiator, with a behavioural OR-merge RAM (1-cycle read,
// read-during-write returns old data) attached to the RAM pins.
module tb_fakeram_256x64_initiator;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_was_write;
    logic        ram_ce;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [63:0] ram_wd;
    logic [63:0] ram_rd;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] mem [256];
    logic [64:0] rsp_q[$];
    int          acc_q[$];
    logic        st_we[$];
    logic [7:0]  st_addr[$];
    logic [63:0] st_wd[$];

    fakeram_256x64_initiator dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_we        (req_we),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_was_write (rsp_was_write),
        .o_ram_ce        (ram_ce),
        .o_ram_we        (ram_we),
        .o_ram_addr      (ram_addr),
        .o_ram_wd        (ram_wd),
        .i_ram_rd        (ram_rd),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_rd = '0;
    end

    always @(posedge clk) begin
        if (ram_ce) begin
            ram_rd <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= mem[ram_addr] | ram_wd;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_was_write, rsp_rdata});
        end
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // One isolated access with rsp_ready high; checks issue, latency and the response word.
    task automatic single_access(input string tag, input logic we, input logic [7:0] a,
                                 input logic [63:0] wd, input logic [63:0] exp);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk1({tag, "_ready"}, req_ready, 1'b1);
        tick();
        clear_req();
        chk1({tag, "_ce"}, ram_ce, 1'b1);
        chk1({tag, "_we"}, ram_we, we);
        chk({tag, "_addr"}, 64'(ram_addr), 64'(a));
        chk({tag, "_wd"}, ram_wd, we ? wd : 64'h0);
        chk1({tag, "_rv_t1"}, rsp_valid, 1'b0);
        tick();
        chk1({tag, "_rv_t2"}, rsp_valid, 1'b0);
        tick();
        chk1({tag, "_rv_lat2"}, rsp_valid, 1'b1);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        chk1({tag, "_was_wr"}, rsp_was_write, we);
        tick();
        chk1({tag, "_rv_done"}, rsp_valid, 1'b0);
        chk1({tag, "_busy_done"}, busy, 1'b0);
    endtask

    // Presents st_* requests back to back; a request advances only when accepted.
    task automatic stream(input int n, input int max_cyc, output int acc);
        int  k;
        logic go;
        k = 0;
        for (int c = 0; c < max_cyc && k < n; c++) begin
            req_valid = 1'b1;
            req_we    = st_we[k];
            req_addr  = st_addr[k];
            req_wdata = st_wd[k];
            go = req_ready;
            tick();
            if (go) k++;
        end
        clear_req();
        acc = k;
    endtask

    task automatic wait_rsp(input string tag, input int n);
        int b;
        b = 0;
        while (rsp_q.size() < n && b < 200) begin
            tick();
            b++;
        end
        chk({tag, "_rsp_count"}, 64'(rsp_q.size()), 64'(n));
    endtask

    task automatic clear_st();
        st_we.delete();
        st_addr.delete();
        st_wd.delete();
    endtask

    int acc;

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b0;
        clear_req();
        tick();
        tick();
        chk1("rst_ready_low", req_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk1("rst_ready_high", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk1("rst_was_write", rsp_was_write, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ram_ce", ram_ce, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", 64'(ram_addr), 64'h0);
        chk("rst_ram_wd", ram_wd, 64'h0);

        rsp_ready = 1'b1;
        single_access("wr_ff", 1'b1, 8'h10, 64'h00FF, 64'h0);
        single_access("rd_ff", 1'b0, 8'h10, 64'h0, 64'h00FF);
        single_access("wr_f000", 1'b1, 8'h10, 64'hF000, 64'h00FF);
        single_access("rd_merge", 1'b0, 8'h10, 64'h0, 64'hF0FF);

        single_access("pre_w20", 1'b1, 8'h20, 64'h1111, 64'h0);
        single_access("pre_w21", 1'b1, 8'h21, 64'h2222, 64'h0);
        single_access("pre_w22", 1'b1, 8'h22, 64'h3333, 64'h0);
        single_access("pre_w23", 1'b1, 8'h23, 64'h4444, 64'h0);

        // Backpressure: six reads, only four credits.
        rsp_ready = 1'b0;
        rsp_q.delete();
        clear_st();
        for (int i = 0; i < 6; i++) begin
            st_we.push_back(1'b0);
            st_addr.push_back(8'(8'h20 + i));
            st_wd.push_back(64'h0);
        end
        stream(6, 12, acc);
        chk("bp_accepts", 64'(acc), 64'd4);
        chk1("bp_ready_low", req_ready, 1'b0);
        chk1("bp_rsp_valid", rsp_valid, 1'b1);
        chk1("bp_busy", busy, 1'b1);
        rsp_ready = 1'b1;
        wait_rsp("bp", 4);
        if (rsp_q.size() == 4) begin
            chk("bp_rsp0", 64'(rsp_q[0]), {31'h0, 1'b0, 32'h1111} & 64'hFFFF_FFFF_FFFF_FFFF);
            chk1("bp_rsp0_wr", rsp_q[0][64], 1'b0);
            chk("bp_rsp1", rsp_q[1][63:0], 64'h2222);
            chk("bp_rsp2", rsp_q[2][63:0], 64'h3333);
            chk("bp_rsp3", rsp_q[3][63:0], 64'h4444);
        end
        tick();
        chk1("bp_idle_busy", busy, 1'b0);

        // Full-rate stream: 32 writes then 32 reads at addresses 0xFF down to 0xE0.
        clear_st();
        for (int i = 0; i < 32; i++) begin
            st_we.push_back(1'b1);
            st_addr.push_back(8'(8'hFF - i));
            st_wd.push_back(64'hA5A5_0000_0000_0000 | 64'(8'hFF - i));
        end
        rsp_q.delete();
        acc_q.delete();
        stream(32, 100, acc);
        chk("tp_wr_accepts", 64'(acc), 64'd32);
        if (acc_q.size() == 32) chk("tp_wr_span", 64'(acc_q[31] - acc_q[0]), 64'd31);
        wait_rsp("tp_wr", 32);
        for (int i = 0; i < 32 && i < rsp_q.size(); i++) begin
            chk1($sformatf("tp_wr_flag%0d", i), rsp_q[i][64], 1'b1);
            chk($sformatf("tp_wr_old%0d", i), rsp_q[i][63:0], 64'h0);
        end
        for (int i = 0; i < 32; i++) st_we[i] = 1'b0;
        rsp_q.delete();
        acc_q.delete();
        stream(32, 100, acc);
        chk("tp_rd_accepts", 64'(acc), 64'd32);
        if (acc_q.size() == 32) chk("tp_rd_span", 64'(acc_q[31] - acc_q[0]), 64'd31);
        wait_rsp("tp_rd", 32);
        for (int i = 0; i < 32 && i < rsp_q.size(); i++) begin
            chk1($sformatf("tp_rd_flag%0d", i), rsp_q[i][64], 1'b0);
            chk($sformatf("tp_rd_data%0d", i), rsp_q[i][63:0],
                64'hA5A5_0000_0000_0000 | 64'(8'hFF - i));
        end
        tick();

        // Reset with two accesses in flight and two responses queued.
        rsp_ready = 1'b0;
        clear_st();
        for (int i = 0; i < 4; i++) begin
            st_we.push_back(1'b0);
            st_addr.push_back(8'(8'h20 + i));
            st_wd.push_back(64'h0);
        end
        stream(4, 20, acc);
        chk("mr_accepts", 64'(acc), 64'd4);
        chk1("mr_pre_ce", ram_ce, 1'b1);
        chk1("mr_pre_rsp_valid", rsp_valid, 1'b1);
        chk1("mr_pre_ready", req_ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk1("mr_rsp_valid", rsp_valid, 1'b0);
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_ram_ce", ram_ce, 1'b0);
        chk1("mr_ram_we", ram_we, 1'b0);
        chk1("mr_ready", req_ready, 1'b1);
        single_access("mr_after", 1'b0, 8'h10, 64'h0, 64'hF0FF);

        for (int i = 0; i < 100; i++) begin
            tick();
            chk1("idle_ce", ram_ce, 1'b0);
            chk1("idle_known", $isunknown({ram_we, ram_addr, ram_wd}), 1'b0);
        end
        chk1("idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
